// File: rtl/hazard_control_unit_pkg.sv
// Shared decode helpers, mux-select encodings and FSM state type for the
// execute-stage hazard controller.
package hazard_control_unit_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] SEL_REG  = 2'd0;
    localparam logic [1:0] SEL_Z5   = 2'd1;
    localparam logic [1:0] SEL_Z4   = 2'd2;
    localparam logic [1:0] SEL_HOLD = 2'd3;

    localparam logic [1:0] IR4_PASS = 2'd0;
    localparam logic [1:0] IR4_NOP  = 2'd1;
    localparam logic [1:0] IR4_HOLD = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic writes_reg(input logic [6:0] op, input logic [4:0] rd);
        logic w;
        case (op)
            OP_RTYPE, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: w = 1'b1;
            default:                                                      w = 1'b0;
        endcase
        return w && (rd != 5'd0);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        logic u;
        case (op)
            OP_RTYPE, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH: u = 1'b1;
            default:                                                  u = 1'b0;
        endcase
        return u;
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        logic u;
        case (op)
            OP_RTYPE, OP_STORE, OP_BRANCH: u = 1'b1;
            default:                       u = 1'b0;
        endcase
        return u;
    endfunction

    function automatic logic is_load(input logic [6:0] op);
        return op == OP_LOAD;
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      ir3_output;
    logic [31:0]      ir4_output;
    logic [31:0]      ir5_output;
    logic             branch_control_output;
    logic             mem_wait;
    logic [1:0]       select_operand1;
    logic [1:0]       select_operand2;
    logic [1:0]       select_md4;
    logic [1:0]       select_ir4;
    logic             select_pc4z4;
    logic             stall_front;
    logic             flush_front;
    logic             hold_mem;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ir3_output, ir4_output, ir5_output, branch_control_output, mem_wait,
        input  select_operand1, select_operand2, select_md4, select_ir4, select_pc4z4,
        input  stall_front, flush_front, hold_mem, stall_count, flush_count
    );

    modport slave (
        input  ir3_output, ir4_output, ir5_output, branch_control_output, mem_wait,
        output select_operand1, select_operand2, select_md4, select_ir4, select_pc4z4,
        output stall_front, flush_front, hold_mem, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_fwd_match.sv
// Forward-source selection for one source register against IR4/IR5.
// IR4 wins over IR5; a load in IR4 cannot forward yet and raises load_match.
module hazard_fwd_match
    import hazard_control_unit_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [6:0] op4,
    input  logic [4:0] rd4,
    input  logic [6:0] op5,
    input  logic [4:0] rd5,
    output logic [1:0] sel,
    output logic       load_match
);
    logic hit4;
    logic hit5;

    assign hit4 = writes_reg(op4, rd4) && (rd4 == rs);
    assign hit5 = writes_reg(op5, rd5) && (rd5 == rs);

    always_comb begin
        sel = SEL_REG;
        if (hit4 && !is_load(op4)) begin
            sel = SEL_Z4;
        end else if (hit5) begin
            sel = SEL_Z5;
        end
    end

    assign load_match = hit4 && is_load(op4);

endmodule

// File: rtl/hazard_control_unit.sv
// Execute-stage pipeline controller: operand/store-data forwarding, load-use
// stalls, taken-branch flushes and memory-wait holds, with event counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input logic              clk,
    input logic              reset,
    hazard_control_unit_if.slave bus
);
    logic [6:0] op3;
    logic [6:0] op4;
    logic [6:0] op5;
    logic [4:0] rs1_3;
    logic [4:0] rs2_3;
    logic [4:0] rd4;
    logic [4:0] rd5;

    assign op3   = bus.ir3_output[6:0];
    assign rs1_3 = bus.ir3_output[19:15];
    assign rs2_3 = bus.ir3_output[24:20];
    assign op4   = bus.ir4_output[6:0];
    assign rd4   = bus.ir4_output[11:7];
    assign op5   = bus.ir5_output[6:0];
    assign rd5   = bus.ir5_output[11:7];

    // Lanes: 0 = operand1 (rs1), 1 = operand2 (rs2), 2 = store data (rs2)
    logic [4:0] rs_idx   [3];
    logic [1:0] fwd_sel  [3];
    logic       ld_match [3];

    assign rs_idx[0] = rs1_3;
    assign rs_idx[1] = rs2_3;
    assign rs_idx[2] = rs2_3;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_fwd
            hazard_fwd_match u_match (
                .rs         (rs_idx[gi]),
                .op4        (op4),
                .rd4        (rd4),
                .op5        (op5),
                .rd5        (rd5),
                .sel        (fwd_sel[gi]),
                .load_match (ld_match[gi])
            );
        end
    endgenerate

    logic unused_fields;
    assign unused_fields = ^{bus.ir3_output[14:7], bus.ir3_output[31:25],
                             bus.ir4_output[31:12], bus.ir5_output[31:12], ld_match[2]};

    state_t           state_reg;
    logic [2:0]       fcnt_reg;
    logic [CNT_W-1:0] stall_count_reg;
    logic [CNT_W-1:0] flush_count_reg;

    logic load_use;
    assign load_use = (state_reg == ST_RUN) &&
                      ((uses_rs1(op3) && ld_match[0]) || (uses_rs2(op3) && ld_match[1]));

    logic [1:0] sel_op1;
    logic [1:0] sel_op2;
    logic [1:0] sel_md4;
    logic [1:0] sel_ir4;
    logic       sel_pc4z4;
    logic       stall_f;
    logic       flush_f;
    logic       hold_m;

    // Priority: reset > mem_wait > flush (taken branch or FLUSH state) > load-use
    always_comb begin
        sel_op1   = uses_rs1(op3) ? fwd_sel[0] : SEL_REG;
        sel_op2   = uses_rs2(op3) ? fwd_sel[1] : SEL_REG;
        sel_md4   = (op3 == OP_STORE) ? fwd_sel[2] : SEL_REG;
        sel_pc4z4 = !((op4 == OP_JAL) || (op4 == OP_JALR));
        sel_ir4   = IR4_PASS;
        stall_f   = 1'b0;
        flush_f   = 1'b0;
        hold_m    = 1'b0;
        if (reset) begin
            sel_op1   = SEL_REG;
            sel_op2   = SEL_REG;
            sel_md4   = SEL_REG;
            sel_pc4z4 = 1'b0;
            sel_ir4   = IR4_NOP;
            flush_f   = 1'b1;
        end else if (bus.mem_wait) begin
            hold_m  = 1'b1;
            stall_f = 1'b1;
            sel_ir4 = IR4_HOLD;
            sel_md4 = SEL_HOLD;
        end else if ((state_reg == ST_FLUSH) || bus.branch_control_output) begin
            sel_ir4 = IR4_NOP;
            flush_f = 1'b1;
        end else if (load_use) begin
            sel_ir4 = IR4_NOP;
            stall_f = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_RUN;
            fcnt_reg        <= 3'd0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else if (!bus.mem_wait) begin
            case (state_reg)
                ST_RUN, ST_STALL: begin
                    // A taken branch overrides a load-use pair: the consumer is wrong-path.
                    if (bus.branch_control_output) begin
                        if (flush_count_reg != '1) begin
                            flush_count_reg <= flush_count_reg + CNT_W'(1);
                        end
                        if (FLUSH_CYCLES > 1) begin
                            state_reg <= ST_FLUSH;
                            fcnt_reg  <= 3'(FLUSH_CYCLES - 1);
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end else if (load_use) begin
                        if (stall_count_reg != '1) begin
                            stall_count_reg <= stall_count_reg + CNT_W'(1);
                        end
                        state_reg <= ST_STALL;
                    end else begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    fcnt_reg <= fcnt_reg - 3'd1;
                    if (fcnt_reg <= 3'd1) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                    fcnt_reg  <= 3'd0;
                end
            endcase
        end
    end

    assign bus.select_operand1 = sel_op1;
    assign bus.select_operand2 = sel_op2;
    assign bus.select_md4      = sel_md4;
    assign bus.select_ir4      = sel_ir4;
    assign bus.select_pc4z4    = sel_pc4z4;
    assign bus.stall_front     = stall_f;
    assign bus.flush_front     = flush_f;
    assign bus.hold_mem        = hold_m;
    assign bus.stall_count     = stall_count_reg;
    assign bus.flush_count     = flush_count_reg;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scenario bench for hazard_control_unit: per-cycle stimulus rows, expected
// control vectors queued on drive and popped/compared mid-cycle.
module tb_hazard_control_unit;
    import hazard_control_unit_pkg::*;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_control_unit #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] ir3;
        logic [31:0] ir4;
        logic [31:0] ir5;
        logic        br;
        logic        mw;
        logic [11:0] ctrl;
        logic [15:0] s_cnt;
        logic [15:0] f_cnt;
    } stim_t;

    stim_t exp_q[$];

    logic [11:0] ctrl_obs;
    assign ctrl_obs = {bus.select_operand1, bus.select_operand2, bus.select_md4, bus.select_ir4,
                       bus.select_pc4z4, bus.stall_front, bus.flush_front, bus.hold_mem};

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] rtype(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), OP_RTYPE};
    endfunction
    function automatic logic [31:0] itype(input logic [6:0] op, input int rd, input int rs1);
        return {12'h000, 5'(rs1), 3'b010, 5'(rd), op};
    endfunction
    function automatic logic [31:0] stype(input int rs2, input int rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], OP_STORE};
    endfunction
    function automatic logic [31:0] btype(input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'b0, OP_BRANCH};
    endfunction
    function automatic logic [31:0] jal(input int rd);
        return {20'h0, 5'(rd), OP_JAL};
    endfunction

    // {op1, op2, md4, ir4, pc4z4, stall_front, flush_front, hold_mem}
    function automatic logic [11:0] pk(input int o1, input int o2, input int md, input int ir,
                                       input int pc, input int sf, input int ff, input int hm);
        return {2'(o1), 2'(o2), 2'(md), 2'(ir), 1'(pc), 1'(sf), 1'(ff), 1'(hm)};
    endfunction

    function automatic stim_t mk(input string tag, input logic [31:0] ir3, input logic [31:0] ir4,
                                 input logic [31:0] ir5, input logic br, input logic mw,
                                 input logic [11:0] ctrl, input int s, input int f);
        stim_t r;
        r.tag = tag; r.ir3 = ir3; r.ir4 = ir4; r.ir5 = ir5; r.br = br; r.mw = mw;
        r.ctrl = ctrl; r.s_cnt = 16'(s); r.f_cnt = 16'(f);
        return r;
    endfunction

    logic [11:0] IDLE, RSTV, FLSH, STL, HOLD;

    task automatic apply(input stim_t r);
        bus.ir3_output            = r.ir3;
        bus.ir4_output            = r.ir4;
        bus.ir5_output            = r.ir5;
        bus.branch_control_output = r.br;
        bus.mem_wait              = r.mw;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(mk("rst", NOP, NOP, NOP, 1'b0, 1'b0, IDLE, 0, 0));
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(mk("r", rtype(6, 5, 3), rtype(5, 1, 2), NOP, 1'b0, 1'b0, IDLE, 0, 0));
        @(negedge clk);
        checks++;
        if (ctrl_obs !== RSTV) begin
            errors++;
            $display("FAIL reset_outputs ctrl got=%03h want=%03h", ctrl_obs, RSTV);
        end
        checks++;
        if ({bus.stall_count, bus.flush_count} !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters got=%0d/%0d want=0/0", bus.stall_count, bus.flush_count);
        end
        $display("txn reset_hold ctrl=%03h", ctrl_obs);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl_obs !== pk(2, 0, 0, 0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_release ctrl got=%03h want=%03h", ctrl_obs, pk(2, 0, 0, 0, 1, 0, 0, 0));
        end
        $display("txn reset_release ctrl=%03h", ctrl_obs);
        @(posedge clk);
        #1;
    endtask

    task automatic test_forward();
        stim_t rows[$];
        stim_t e;
        do_reset();
        rows.push_back(mk("fwd_z4_rs1",  rtype(6, 5, 3), rtype(5, 1, 2), NOP, 0, 0, pk(2,0,0,0,1,0,0,0), 0, 0));
        rows.push_back(mk("fwd_z5_rs2",  rtype(6, 5, 3), NOP, itype(OP_IMM, 3, 0), 0, 0, pk(0,1,0,0,1,0,0,0), 0, 0));
        rows.push_back(mk("fwd_prio_z4", rtype(6, 5, 5), rtype(5, 1, 2), itype(OP_IMM, 5, 0), 0, 0, pk(2,2,0,0,1,0,0,0), 0, 0));
        rows.push_back(mk("fwd_jal",     rtype(2, 1, 0), jal(1), NOP, 0, 0, pk(2,0,0,0,0,0,0,0), 0, 0));
        rows.push_back(mk("fwd_jalr",    rtype(2, 4, 1), itype(OP_JALR, 1, 3), itype(OP_IMM, 4, 0), 0, 0, pk(1,2,0,0,0,0,0,0), 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctrl_obs !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl got=%03h want=%03h", e.tag, ctrl_obs, e.ctrl);
            end
            checks++;
            if ({bus.stall_count, bus.flush_count} !== {e.s_cnt, e.f_cnt}) begin
                errors++;
                $display("FAIL %s counts got=%0d/%0d want=%0d/%0d", e.tag, bus.stall_count, bus.flush_count, e.s_cnt, e.f_cnt);
            end
            $display("txn %s ctrl=%03h stall=%0d flush=%0d", e.tag, ctrl_obs, bus.stall_count, bus.flush_count);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        stim_t rows[$];
        stim_t e;
        do_reset();
        rows.push_back(mk("lu_detect",  rtype(8, 7, 7), itype(OP_LOAD, 7, 1), NOP, 0, 0, STL, 0, 0));
        rows.push_back(mk("lu_stall_z5", rtype(8, 7, 7), NOP, itype(OP_LOAD, 7, 1), 0, 0, pk(1,1,0,0,1,0,0,0), 1, 0));
        rows.push_back(mk("lu_after",   NOP, rtype(8, 7, 7), NOP, 0, 0, IDLE, 1, 0));
        rows.push_back(mk("lu_rd_x0",   rtype(8, 0, 0), itype(OP_LOAD, 0, 1), NOP, 0, 0, IDLE, 1, 0));
        rows.push_back(mk("lu_rs2",     rtype(8, 1, 9), itype(OP_LOAD, 9, 1), NOP, 0, 0, STL, 1, 0));
        rows.push_back(mk("lu_rs2_z5",  rtype(8, 1, 9), NOP, itype(OP_LOAD, 9, 1), 0, 0, pk(0,1,0,0,1,0,0,0), 2, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctrl_obs !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl got=%03h want=%03h", e.tag, ctrl_obs, e.ctrl);
            end
            checks++;
            if ({bus.stall_count, bus.flush_count} !== {e.s_cnt, e.f_cnt}) begin
                errors++;
                $display("FAIL %s counts got=%0d/%0d want=%0d/%0d", e.tag, bus.stall_count, bus.flush_count, e.s_cnt, e.f_cnt);
            end
            $display("txn %s ctrl=%03h stall=%0d flush=%0d", e.tag, ctrl_obs, bus.stall_count, bus.flush_count);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_store_fwd();
        stim_t rows[$];
        stim_t e;
        do_reset();
        rows.push_back(mk("md4_z5",       stype(9, 2, 4), NOP, itype(OP_IMM, 9, 0), 0, 0, pk(0,1,1,0,1,0,0,0), 0, 0));
        rows.push_back(mk("md4_z4",       stype(9, 2, 4), itype(OP_IMM, 9, 0), NOP, 0, 0, pk(0,2,2,0,1,0,0,0), 0, 0));
        rows.push_back(mk("md4_nonstore", rtype(1, 9, 9), itype(OP_IMM, 9, 0), NOP, 0, 0, pk(2,2,0,0,1,0,0,0), 0, 0));
        rows.push_back(mk("md4_base_only", stype(3, 9, 0), itype(OP_IMM, 9, 0), NOP, 0, 0, pk(2,0,0,0,1,0,0,0), 0, 0));
        rows.push_back(mk("md4_load_ir4", stype(9, 2, 4), itype(OP_LOAD, 9, 1), NOP, 0, 0, STL, 0, 0));
        rows.push_back(mk("md4_after_lu", stype(9, 2, 4), NOP, itype(OP_LOAD, 9, 1), 0, 0, pk(0,1,1,0,1,0,0,0), 1, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctrl_obs !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl got=%03h want=%03h", e.tag, ctrl_obs, e.ctrl);
            end
            checks++;
            if ({bus.stall_count, bus.flush_count} !== {e.s_cnt, e.f_cnt}) begin
                errors++;
                $display("FAIL %s counts got=%0d/%0d want=%0d/%0d", e.tag, bus.stall_count, bus.flush_count, e.s_cnt, e.f_cnt);
            end
            $display("txn %s ctrl=%03h stall=%0d flush=%0d", e.tag, ctrl_obs, bus.stall_count, bus.flush_count);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        stim_t rows[$];
        stim_t e;
        do_reset();
        rows.push_back(mk("br_trigger",   NOP, btype(1, 2), NOP, 1, 0, FLSH, 0, 0));
        rows.push_back(mk("br_flush_2nd", NOP, NOP, NOP, 1, 0, FLSH, 0, 1));
        rows.push_back(mk("br_done",      NOP, NOP, NOP, 0, 0, IDLE, 0, 1));
        rows.push_back(mk("br_vs_lu",     rtype(8, 7, 7), itype(OP_LOAD, 7, 1), NOP, 1, 0, FLSH, 0, 1));
        rows.push_back(mk("br_vs_lu_fl",  NOP, NOP, itype(OP_LOAD, 7, 1), 0, 0, FLSH, 0, 2));
        rows.push_back(mk("br_vs_lu_done", NOP, NOP, NOP, 0, 0, IDLE, 0, 2));
        rows.push_back(mk("br_stall_a",   rtype(8, 7, 7), itype(OP_LOAD, 7, 1), NOP, 0, 0, STL, 0, 2));
        rows.push_back(mk("br_in_stall",  rtype(8, 7, 7), btype(3, 4), itype(OP_LOAD, 7, 1), 1, 0, pk(1,1,0,1,1,0,1,0), 1, 2));
        rows.push_back(mk("br_stall_fl",  NOP, NOP, NOP, 0, 0, FLSH, 1, 3));
        rows.push_back(mk("br_stall_done", NOP, NOP, NOP, 0, 0, IDLE, 1, 3));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctrl_obs !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl got=%03h want=%03h", e.tag, ctrl_obs, e.ctrl);
            end
            checks++;
            if ({bus.stall_count, bus.flush_count} !== {e.s_cnt, e.f_cnt}) begin
                errors++;
                $display("FAIL %s counts got=%0d/%0d want=%0d/%0d", e.tag, bus.stall_count, bus.flush_count, e.s_cnt, e.f_cnt);
            end
            $display("txn %s ctrl=%03h stall=%0d flush=%0d", e.tag, ctrl_obs, bus.stall_count, bus.flush_count);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t rows[$];
        stim_t e;
        do_reset();
        rows.push_back(mk("mw_trigger",  NOP, btype(1, 2), NOP, 1, 0, FLSH, 0, 0));
        rows.push_back(mk("mw_hold_1",   NOP, NOP, NOP, 0, 1, HOLD, 0, 1));
        rows.push_back(mk("mw_hold_2",   NOP, NOP, NOP, 0, 1, HOLD, 0, 1));
        rows.push_back(mk("mw_hold_3",   NOP, NOP, NOP, 0, 1, HOLD, 0, 1));
        rows.push_back(mk("mw_flush_rest", NOP, NOP, NOP, 0, 0, FLSH, 0, 1));
        rows.push_back(mk("mw_flush_done", NOP, NOP, NOP, 0, 0, IDLE, 0, 1));
        rows.push_back(mk("mw_lu_hold",  rtype(8, 7, 7), itype(OP_LOAD, 7, 1), NOP, 0, 1, HOLD, 0, 1));
        rows.push_back(mk("mw_lu_stall", rtype(8, 7, 7), itype(OP_LOAD, 7, 1), NOP, 0, 0, STL, 0, 1));
        rows.push_back(mk("mw_lu_z5",    rtype(8, 7, 7), NOP, itype(OP_LOAD, 7, 1), 0, 0, pk(1,1,0,0,1,0,0,0), 1, 1));
        rows.push_back(mk("mw_br_held",  NOP, btype(1, 2), NOP, 1, 1, HOLD, 1, 1));
        rows.push_back(mk("mw_br_none",  NOP, NOP, NOP, 0, 0, IDLE, 1, 1));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctrl_obs !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl got=%03h want=%03h", e.tag, ctrl_obs, e.ctrl);
            end
            checks++;
            if ({bus.stall_count, bus.flush_count} !== {e.s_cnt, e.f_cnt}) begin
                errors++;
                $display("FAIL %s counts got=%0d/%0d want=%0d/%0d", e.tag, bus.stall_count, bus.flush_count, e.s_cnt, e.f_cnt);
            end
            $display("txn %s ctrl=%03h stall=%0d flush=%0d", e.tag, ctrl_obs, bus.stall_count, bus.flush_count);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t rows[$];
        stim_t e;
        do_reset();
        rows.push_back(mk("ms_trigger", NOP, btype(1, 2), NOP, 1, 0, FLSH, 0, 0));
        rows.push_back(mk("ms_flush",   NOP, NOP, NOP, 0, 0, FLSH, 0, 1));
        rows.push_back(mk("ms_lu",      rtype(8, 7, 7), itype(OP_LOAD, 7, 1), NOP, 0, 0, STL, 0, 1));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctrl_obs !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl got=%03h want=%03h", e.tag, ctrl_obs, e.ctrl);
            end
            checks++;
            if ({bus.stall_count, bus.flush_count} !== {e.s_cnt, e.f_cnt}) begin
                errors++;
                $display("FAIL %s counts got=%0d/%0d want=%0d/%0d", e.tag, bus.stall_count, bus.flush_count, e.s_cnt, e.f_cnt);
            end
            $display("txn %s ctrl=%03h stall=%0d flush=%0d", e.tag, ctrl_obs, bus.stall_count, bus.flush_count);
            @(posedge clk);
            #1;
        end
        // Now in STALL with stall=1/flush=1; assert reset between clock edges.
        apply(mk("ms_stall", rtype(8, 7, 7), NOP, itype(OP_LOAD, 7, 1), 1'b0, 1'b0, IDLE, 0, 0));
        #1 rst = 1'b1;
        #1;
        checks++;
        if (ctrl_obs !== RSTV) begin
            errors++;
            $display("FAIL ms_async_reset ctrl got=%03h want=%03h", ctrl_obs, RSTV);
        end
        checks++;
        if ({bus.stall_count, bus.flush_count} !== 32'd0) begin
            errors++;
            $display("FAIL ms_async_counters got=%0d/%0d want=0/0", bus.stall_count, bus.flush_count);
        end
        $display("txn ms_async_reset ctrl=%03h stall=%0d flush=%0d", ctrl_obs, bus.stall_count, bus.flush_count);
        @(posedge clk);
        #1 rst = 1'b0;
        rows.delete();
        rows.push_back(mk("ms_run_again", rtype(8, 7, 7), itype(OP_LOAD, 7, 1), NOP, 0, 0, STL, 0, 0));
        rows.push_back(mk("ms_stall_z5",  rtype(8, 7, 7), NOP, itype(OP_LOAD, 7, 1), 0, 0, pk(1,1,0,0,1,0,0,0), 1, 0));
        rows.push_back(mk("x0_no_fwd",    rtype(3, 0, 0), rtype(0, 1, 2), itype(OP_IMM, 0, 0), 0, 0, IDLE, 1, 0));
        rows.push_back(mk("x0_store",     stype(0, 1, 0), rtype(0, 2, 3), itype(OP_IMM, 0, 0), 0, 0, IDLE, 1, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (ctrl_obs !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl got=%03h want=%03h", e.tag, ctrl_obs, e.ctrl);
            end
            checks++;
            if ({bus.stall_count, bus.flush_count} !== {e.s_cnt, e.f_cnt}) begin
                errors++;
                $display("FAIL %s counts got=%0d/%0d want=%0d/%0d", e.tag, bus.stall_count, bus.flush_count, e.s_cnt, e.f_cnt);
            end
            $display("txn %s ctrl=%03h stall=%0d flush=%0d", e.tag, ctrl_obs, bus.stall_count, bus.flush_count);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time budget");
        $fatal(1);
    end

    initial begin
        IDLE = pk(0, 0, 0, 0, 1, 0, 0, 0);
        RSTV = pk(0, 0, 0, 1, 0, 0, 1, 0);
        FLSH = pk(0, 0, 0, 1, 1, 0, 1, 0);
        STL  = pk(0, 0, 0, 1, 1, 1, 0, 0);
        HOLD = pk(0, 0, 3, 2, 1, 1, 0, 1);
        test_reset();
        test_forward();
        test_load_use();
        test_store_fwd();
        test_branch();
        test_mem_wait();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
